rsu_cmd_sequencer: RTL and testbench
====================================

// Module: rsu_cmd_sequencer
// PURPOSE
//  Parses UART command bytes ('S' set-image, 'C' get-image) and sequences the dual-image remote-update CSR port.
//  Sits in Top between the UART byte receiver/transmitter and the remote system update core.
//  Drives config-select writes, optional reconfig trigger and status reads; returns replies over the UART TX handshake.
// PARAMETERS
//  CLOCK       100_000_000  system clock, Hz (timeout scaling only)
//  RX_TIMEOUT  10           inter-byte gap limit, in units of CLOCK/1_000_000 cycles (us); 0 disables
//  UNLOCK_KEY  8'h93        required third byte of an 'S' frame
// PORTS
//  inclk      in   1   system clock
//  reset      in   1   asynchronous, active-high reset
//  rx_valid   in   1   one-cycle strobe: rx_data holds a received byte
//  rx_data    in   8   received byte
//  tx_ready   in   1   UART TX can accept a byte
//  tx_valid   out  1   tx_data valid; byte transferred on tx_valid&tx_ready
//  tx_data    out  8   byte to transmit
//  ru_busy    in   1   update core busy; no access may start while high
//  ru_write   out  1   one-cycle CSR write strobe
//  ru_read    out  1   one-cycle CSR read strobe
//  ru_addr    out  3   CSR address
//  ru_wdata   out  32  CSR write data
//  ru_rdata   in   32  CSR read data, valid first cycle ru_busy low after ru_read
//  cur_img    out  1   last image selected by an accepted 'S'
//  err        out  1   one-cycle strobe: frame rejected
// BEHAVIOUR
//  Reset: state IDLE; tx_valid, ru_write, ru_read, err, cur_img = 0; ru_addr = 0; ru_wdata = 0; tx_data = 0; timer cleared.
//  Frames: 'S'(8'h53) ARG KEY | 'C'(8'h43). ARG[0] = image select, ARG[2] = trigger reconfig, ARG[1] ignored.
//  States / transitions:
//   IDLE    : rx 'S' -> GET_ARG; rx 'C' -> RD_REQ; any other byte dropped silently.
//   GET_ARG : rx byte -> latch ARG -> GET_KEY; ARG[7:3]!=0 -> ERR.
//   GET_KEY : rx byte == UNLOCK_KEY -> WR_SEL; else -> ERR.
//   WR_SEL  : wait !ru_busy; pulse ru_write, addr 3'd1, wdata {30'b0,ARG[0],1'b1}; cur_img <= ARG[0].
//             Next cycle: ARG[2] ? WR_TRIG : ACK.
//   WR_TRIG : wait !ru_busy; pulse ru_write, addr 3'd0, wdata 32'h1 -> ACK.
//   RD_REQ  : wait !ru_busy; pulse ru_read, addr 3'd2 -> RD_WAIT.
//   RD_WAIT : one cycle after strobe, first cycle !ru_busy: capture ru_rdata[7:0] -> TX_HDR.
//   TX_HDR  : tx_data 'C' until handshake -> TX_STAT.
//   TX_STAT : tx_data = captured status until handshake -> IDLE.
//   ACK/ERR : see CONFIGURATION; ERR pulses err for exactly one cycle.
//  Strobes are single-cycle; ru_addr/ru_wdata hold value until next access. tx_valid, once high, holds with stable
//   tx_data until tx_ready (AXI-style; no withdrawal).
//  Timeout: in GET_ARG/GET_KEY a free counter restarts on each rx_valid; reaching RX_TIMEOUT*(CLOCK/1e6) cycles -> ERR.
//  rx_valid outside IDLE/GET_ARG/GET_KEY is dropped (no queueing); rx_valid in same cycle as timeout expiry: timeout wins.
//  Byte accepted cycle N -> state change visible cycle N+1. Write strobe earliest 1 cycle after KEY if ru_busy low.
//  ru_busy held high: sequencer waits indefinitely in the access state (no timeout on CSR side).
//  Reset asserted mid-frame or mid-transmit: immediate return to IDLE, all outputs to reset values; partial frame lost.
// CONFIGURATION
//  RSU_CMD_ACK_EN defined:   ACK sends 8'h4B ('K'), ERR sends 8'h45 ('E') via TX handshake, then IDLE.
//  RSU_CMD_ACK_EN undefined: ACK -> IDLE in one cycle; ERR -> IDLE in one cycle; no TX bytes except 'C' replies.
//  err strobe and cur_img behaviour identical in both builds.
// TESTING
//  1. 'S',8'h04,8'h93, ru_busy=0 -> write addr1 wdata 32'h1, then write addr0 wdata 32'h1; cur_img=0; [ACK_EN] tx 'K'.
//  2. 'S',8'h01,8'h93 -> single write addr1 wdata 32'h3, no trigger write; cur_img=1.
//  3. 'S',8'h04,8'h55 -> err pulse, no ru_write; [ACK_EN] tx 'E'; next 'C' still processed normally.
//  4. 'C', ru_rdata=32'h0000_00A5 -> ru_read addr2, tx 'C' then 8'hA5; hold tx_ready=0 20 cycles: bytes held stable.
//  5. 'S' then no byte for RX_TIMEOUT us -> err pulse, IDLE; following 'S',8'h00,8'h93 accepted.
//  6. ru_busy high 50 cycles at WR_SEL, reset pulsed during wait -> no strobe, all outputs reset, IDLE.

Source files
------------

// File: rtl/rsu_cmd_sequencer.sv
// rsu_cmd_sequencer: parses UART 'S'/'C' frames and sequences remote-update CSR writes/reads.
// Optional feature: define RSU_CMD_ACK_EN to reply 'K' on accepted and 'E' on rejected 'S' frames.
module rsu_cmd_sequencer #(
    parameter int unsigned CLOCK      = 100_000_000,
    parameter int unsigned RX_TIMEOUT = 10,
    parameter logic [7:0]  UNLOCK_KEY = 8'h93
) (
    input  logic        inclk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        ru_busy,
    output logic        ru_write,
    output logic        ru_read,
    output logic [2:0]  ru_addr,
    output logic [31:0] ru_wdata,
    input  logic [31:0] ru_rdata,
    output logic        cur_img,
    output logic        err
);
    localparam int unsigned LIMIT = RX_TIMEOUT * (CLOCK / 1_000_000);

    typedef enum logic [3:0] {
        IDLE, GET_ARG, GET_KEY, WR_SEL, WR_TRIG, RD_REQ, RD_WAIT, TX_HDR, TX_STAT, ACK, ERR, NAK
    } state_t;

    state_t      state, state_n;
    logic        arg_img, arg_trig;
    logic [7:0]  stat;
    logic [31:0] timer;
    logic [2:0]  addr_q;
    logic [31:0] wdata_q;
    logic        waiting, timeout;
    logic        unused_rdata;

    assign unused_rdata = ^ru_rdata[31:8];
    assign waiting = state == GET_ARG || state == GET_KEY;
    assign timeout = LIMIT != 0 && waiting && timer == LIMIT - 1;

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            arg_img  <= 1'b0;
            arg_trig <= 1'b0;
            stat     <= 8'h00;
            timer    <= '0;
            addr_q   <= 3'd0;
            wdata_q  <= 32'h0;
            cur_img  <= 1'b0;
        end else begin
            state <= state_n;
            timer <= (rx_valid || !waiting) ? '0 : timer + 1;
            if (state == GET_ARG && rx_valid) begin
                arg_img  <= rx_data[0];
                arg_trig <= rx_data[2];
            end
            if (state == RD_WAIT && !ru_busy) stat <= ru_rdata[7:0];
            if (ru_write || ru_read) begin
                addr_q  <= ru_addr;
                wdata_q <= ru_wdata;
            end
            if (state == WR_SEL && !ru_busy) cur_img <= arg_img;
        end
    end

    // Address/data show the new access only on its strobe cycle, otherwise the last access.
    always_comb begin
        state_n  = state;
        ru_write = 1'b0;
        ru_read  = 1'b0;
        ru_addr  = addr_q;
        ru_wdata = wdata_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        err      = 1'b0;
        case (state)
            IDLE:    if (rx_valid) state_n = rx_data == 8'h53 ? GET_ARG : (rx_data == 8'h43 ? RD_REQ : IDLE);
            GET_ARG: if (timeout) state_n = ERR;
                     else if (rx_valid) state_n = |rx_data[7:3] ? ERR : GET_KEY;
            GET_KEY: if (timeout) state_n = ERR;
                     else if (rx_valid) state_n = rx_data == UNLOCK_KEY ? WR_SEL : ERR;
            WR_SEL: if (!ru_busy) begin
                ru_write = 1'b1;
                ru_addr  = 3'd1;
                ru_wdata = {30'b0, arg_img, 1'b1};
                state_n  = arg_trig ? WR_TRIG : ACK;
            end
            WR_TRIG: if (!ru_busy) begin
                ru_write = 1'b1;
                ru_addr  = 3'd0;
                ru_wdata = 32'h1;
                state_n  = ACK;
            end
            RD_REQ: if (!ru_busy) begin
                ru_read = 1'b1;
                ru_addr = 3'd2;
                state_n = RD_WAIT;
            end
            RD_WAIT: if (!ru_busy) state_n = TX_HDR;
            TX_HDR: begin
                tx_valid = 1'b1;
                tx_data  = 8'h43;
                if (tx_ready) state_n = TX_STAT;
            end
            TX_STAT: begin
                tx_valid = 1'b1;
                tx_data  = stat;
                if (tx_ready) state_n = IDLE;
            end
`ifdef RSU_CMD_ACK_EN
            ACK: begin
                tx_valid = 1'b1;
                tx_data  = 8'h4B;
                if (tx_ready) state_n = IDLE;
            end
            ERR: begin
                err     = 1'b1;
                state_n = NAK;
            end
            NAK: begin
                tx_valid = 1'b1;
                tx_data  = 8'h45;
                if (tx_ready) state_n = IDLE;
            end
`else
            ACK: state_n = IDLE;
            ERR: begin
                err     = 1'b1;
                state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rsu_cmd_sequencer.sv
// tb_rsu_cmd_sequencer: directed and randomized frames checked against a transaction-level expectation model.
module tb_rsu_cmd_sequencer;
    localparam int LIMIT = 100;

    logic        inclk = 1'b0, reset = 1'b1, rx_valid = 1'b0, tx_ready = 1'b0, ru_busy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [31:0] ru_rdata = 32'h0;
    logic        tx_valid, ru_write, ru_read, cur_img, err;
    logic [7:0]  tx_data;
    logic [2:0]  ru_addr;
    logic [31:0] ru_wdata;

    rsu_cmd_sequencer #(.CLOCK(10_000_000), .RX_TIMEOUT(10), .UNLOCK_KEY(8'h93)) dut (
        .inclk(inclk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .ru_busy(ru_busy),
        .ru_write(ru_write), .ru_read(ru_read), .ru_addr(ru_addr), .ru_wdata(ru_wdata),
        .ru_rdata(ru_rdata), .cur_img(cur_img), .err(err)
    );

    always #5 inclk = ~inclk;

    int          vectors = 0, miscompares = 0;
    logic [35:0] exp_acc[$];
    logic [7:0]  exp_tx[$];
    int          exp_err = 0;
    int          busy_pct = 0, ready_pct = 100;
    logic [31:0] rd_val = 32'h0;
    bit          rd_pending = 1'b0;
    logic        img_mdl = 1'b0;
    logic [2:0]  addr_mdl = 3'd0;
    logic [31:0] wdata_mdl = 32'h0;
    bit          pv = 1'b0, pr = 1'b0;
    logic [7:0]  pd = 8'h00;
    int          cyc = 0;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Environment: random core-busy, TX back-pressure, and read data valid only when the spec says it is.
    initial forever begin
        @(negedge inclk);
        cyc++;
        ru_busy  = int'($urandom_range(0, 99)) < busy_pct;
        tx_ready = int'($urandom_range(0, 99)) < ready_pct;
        ru_rdata = (rd_pending && !ru_busy) ? rd_val : $urandom;
        if (rd_pending && !ru_busy) rd_pending = 1'b0;
    end

    // Compare process: every cycle, DUT activity must match the queued expectations.
    initial forever begin
        logic [35:0] e;
        @(negedge inclk);
        #2;
        if (reset) begin
            exp_acc.delete();
            exp_tx.delete();
            exp_err = 0;
            rd_pending = 1'b0;
            img_mdl = 1'b0;
            addr_mdl = 3'd0;
            wdata_mdl = 32'h0;
            pv = 1'b0;
            continue;
        end
        chk("cur_img", 36'(cur_img), 36'(img_mdl));
        chk("strobe_excl", 36'(ru_write & ru_read), 36'h0);
        if (ru_write || ru_read) begin
            chk("busy_access", 36'(ru_busy), 36'h0);
            e = exp_acc.size() != 0 ? exp_acc.pop_front() : 36'hF_FFFF_FFFF;
            chk("access", {ru_write, ru_addr, ru_write ? ru_wdata : 32'h0}, e);
            if (e != 36'hF_FFFF_FFFF) begin
                addr_mdl = e[34:32];
                if (e[35]) wdata_mdl = e[31:0];
                if (e[35] && e[34:32] == 3'd1) img_mdl = e[1];
                if (!e[35]) rd_pending = 1'b1;
            end
        end else begin
            chk("ru_addr_hold", 36'(ru_addr), 36'(addr_mdl));
            chk("ru_wdata_hold", 36'(ru_wdata), 36'(wdata_mdl));
        end
        if (err) begin
            chk("err_expected", 36'(err), 36'(exp_err > 0));
            if (exp_err > 0) exp_err--;
        end
        if (pv && !pr) begin
            chk("tx_hold_valid", 36'(tx_valid), 36'h1);
            chk("tx_hold_data", 36'(tx_data), 36'(pd));
        end
        if (tx_valid && tx_ready)
            chk("tx_byte", 36'({1'b0, tx_data}), exp_tx.size() != 0 ? 36'({1'b0, exp_tx.pop_front()}) : 36'h100);
        pv = tx_valid;
        pr = tx_ready;
        pd = tx_data;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge inclk);
        rx_valid = 1'b0;
        rx_data  = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_acc.size() != 0 || exp_tx.size() != 0 || exp_err != 0 || rd_pending) && n < 3000) begin
            @(negedge inclk);
            n++;
        end
        chk("idle_timeout", 36'(n >= 3000), 36'h0);
        if (n >= 3000) begin
            exp_acc.delete();
            exp_tx.delete();
            exp_err = 0;
        end
        repeat (4) @(negedge inclk);
    endtask

    task automatic expect_good_s(input logic [7:0] arg);
        exp_acc.push_back({1'b1, 3'd1, 30'b0, arg[0], 1'b1});
        if (arg[2]) exp_acc.push_back({1'b1, 3'd0, 32'h1});
`ifdef RSU_CMD_ACK_EN
        exp_tx.push_back(8'h4B);
`endif
    endtask

    task automatic expect_err();
        exp_err++;
`ifdef RSU_CMD_ACK_EN
        exp_tx.push_back(8'h45);
`endif
    endtask

    task automatic expect_read(input logic [31:0] v);
        rd_val = v;
        exp_acc.push_back({1'b0, 3'd2, 32'h0});
        exp_tx.push_back(8'h43);
        exp_tx.push_back(v[7:0]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b, arg, key;
        int k;
        @(negedge inclk);
        #2;
        chk("rst_outputs", {tx_valid, ru_write, ru_read, err, cur_img, ru_addr, ru_wdata[28:0]}, 36'h0);
        chk("rst_tx_data", 36'(tx_data), 36'h0);
        chk("rst_wdata", 36'(ru_wdata), 36'h0);
        @(negedge inclk);
        reset = 1'b0;
        repeat (3) @(negedge inclk);

        // 1: select image 0 with reconfig trigger, writes on consecutive cycles
        expect_good_s(8'h04);
        send_byte(8'h53); send_byte(8'h04); send_byte(8'h93);
        #2;
        chk("t1_sel_write", {ru_write, ru_addr, ru_wdata}, {1'b1, 3'd1, 32'h1});
        @(negedge inclk); #2;
        chk("t1_trig_write", {ru_write, ru_addr, ru_wdata}, {1'b1, 3'd0, 32'h1});
        wait_idle();
        chk("t1_cur_img", 36'(cur_img), 36'h0);

        // 2: select image 1, no trigger
        expect_good_s(8'h01);
        send_byte(8'h53); send_byte(8'h01); send_byte(8'h93);
        #2;
        chk("t2_sel_write", {ru_write, ru_addr, ru_wdata}, {1'b1, 3'd1, 32'h3});
        @(negedge inclk); #2;
        chk("t2_no_trig", 36'(ru_write), 36'h0);
        wait_idle();
        chk("t2_cur_img", 36'(cur_img), 36'h1);

        // 3: wrong key rejected, then a read still works
        expect_err();
        send_byte(8'h53); send_byte(8'h04); send_byte(8'h55);
        #2;
        chk("t3_err", {err, ru_write}, 36'h2);
        wait_idle();
        expect_read($urandom);
        send_byte(8'h43);
        wait_idle();

        // 4: read reply held under back-pressure
        ready_pct = 0;
        expect_read(32'h0000_00A5);
        send_byte(8'h43);
        repeat (20) @(negedge inclk);
        #2;
        chk("t4_hdr_held", {tx_valid, tx_data}, {1'b1, 8'h43});
        ready_pct = 100;
        @(negedge inclk); @(negedge inclk); #2;
        chk("t4_stat", {tx_valid, tx_data}, {1'b1, 8'hA5});
        wait_idle();

        // 5: inter-byte timeout fires exactly LIMIT cycles after the last byte
        expect_err();
        send_byte(8'h53);
        #2;
        k = 1;
        while (!err && k < LIMIT + 20) begin
            @(negedge inclk); #2;
            k++;
        end
        chk("t5_timeout_cycle", 36'(k), 36'(LIMIT + 1));
        wait_idle();
        expect_good_s(8'h00);
        send_byte(8'h53); send_byte(8'h00); send_byte(8'h93);
        wait_idle();
        // byte one cycle before expiry accepted, byte on the expiry cycle loses
        expect_good_s(8'h01);
        send_byte(8'h53);
        repeat (LIMIT - 2) @(negedge inclk);
        send_byte(8'h01);
        repeat (LIMIT - 2) @(negedge inclk);
        send_byte(8'h93);
        wait_idle();
        expect_err();
        send_byte(8'h53);
        repeat (LIMIT - 1) @(negedge inclk);
        send_byte(8'h00);
        wait_idle();

        // 6: core busy during select write, reset pulsed mid-wait
        busy_pct = 100;
        @(negedge inclk);
        send_byte(8'h53); send_byte(8'h01); send_byte(8'h93);
        repeat (50) @(negedge inclk);
        #5;
        reset = 1'b1;
        #1;
        chk("t6_rst_outputs", {tx_valid, ru_write, ru_read, err, cur_img, ru_addr, ru_wdata[28:0]}, 36'h0);
        chk("t6_rst_wdata", 36'(ru_wdata), 36'h0);
        @(negedge inclk); @(negedge inclk);
        reset = 1'b0;
        busy_pct = 0;
        repeat (2) @(negedge inclk);
        expect_read($urandom);
        send_byte(8'h43);
        wait_idle();

        // Randomized frames
        for (int i = 0; i < 150; i++) begin
            int kind = $urandom_range(0, 9);
            busy_pct  = $urandom_range(0, 60);
            ready_pct = $urandom_range(20, 100);
            @(negedge inclk);
            arg = $urandom_range(0, 7);
            if (kind <= 1) begin
                b = $urandom;
                while (b == 8'h53 || b == 8'h43) b = $urandom;
                send_byte(b);
            end else if (kind <= 4) begin
                expect_good_s(arg);
                send_byte(8'h53); repeat ($urandom_range(0, 5)) @(negedge inclk);
                send_byte(arg); repeat ($urandom_range(0, 5)) @(negedge inclk);
                send_byte(8'h93);
            end else if (kind == 5) begin
                expect_err();
                send_byte(8'h53); repeat ($urandom_range(0, 5)) @(negedge inclk);
                send_byte(8'($urandom) | 8'h08);
            end else if (kind == 6) begin
                key = $urandom;
                if (key == 8'h93) key = 8'h94;
                expect_err();
                send_byte(8'h53); send_byte(arg); repeat ($urandom_range(0, 5)) @(negedge inclk);
                send_byte(key);
            end else if (kind <= 8) begin
                expect_read($urandom);
                send_byte(8'h43);
            end else begin
                expect_err();
                send_byte(8'h53);
                if ($urandom_range(0, 1) == 1) send_byte(arg);
                repeat (LIMIT + $urandom_range(0, 5)) @(negedge inclk);
            end
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
